// File: rtl/braille_stream_encoder.sv
// Streaming ASCII -> 6-dot Grade-1 braille encoder: input FIFO, prefix-aware output FSM.
// Optional number support is compiled in with `define BRAILLE_NUM_EN.
module braille_stream_encoder #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_char,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_cell,
  output logic [AW:0]   fifo_level,
  output logic          err_pulse,
  output logic          busy
);

  localparam logic [1:0]  ST_FETCH   = 2'd0;
  localparam logic [1:0]  ST_PRE     = 2'd1;
  localparam logic [1:0]  ST_CELL    = 2'd2;
  localparam logic [5:0]  CAP_SIGN   = 6'b100000;
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);
`ifdef BRAILLE_NUM_EN
  localparam logic [5:0]  NUM_SIGN   = 6'b111100;
  localparam logic [5:0]  G1_SIGN    = 6'b110000;
`endif

  function automatic logic [5:0] letter_cell(input logic [7:0] ch);
    case (ch)
      "a": letter_cell = 6'b000001;  "b": letter_cell = 6'b000011;
      "c": letter_cell = 6'b001001;  "d": letter_cell = 6'b011001;
      "e": letter_cell = 6'b010001;  "f": letter_cell = 6'b001011;
      "g": letter_cell = 6'b011011;  "h": letter_cell = 6'b010011;
      "i": letter_cell = 6'b001010;  "j": letter_cell = 6'b011010;
      "k": letter_cell = 6'b000101;  "l": letter_cell = 6'b000111;
      "m": letter_cell = 6'b001101;  "n": letter_cell = 6'b011101;
      "o": letter_cell = 6'b010101;  "p": letter_cell = 6'b001111;
      "q": letter_cell = 6'b011111;  "r": letter_cell = 6'b010111;
      "s": letter_cell = 6'b001110;  "t": letter_cell = 6'b011110;
      "u": letter_cell = 6'b100101;  "v": letter_cell = 6'b100111;
      "w": letter_cell = 6'b111010;  "x": letter_cell = 6'b101101;
      "y": letter_cell = 6'b111101;  "z": letter_cell = 6'b110101;
      default: letter_cell = 6'b000000;
    endcase
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push, pop;
  logic [1:0]    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [5:0]    out_cell_q, out_cell_d;
  logic [5:0]    main_cell_q, main_cell_d;
  logic          err_q, err_d;
  logic [7:0]    head;
  logic          dec_ok, dec_pre;
  logic [5:0]    dec_cell, dec_pre_cell;
`ifdef BRAILLE_NUM_EN
  logic          num_mode_q, num_mode_d;
  logic          digit_q, digit_d;
  logic          dec_digit;
`endif

  assign push = in_valid & in_ready;

  // NOTE: FIFO storage has no reset; only pointers and level are cleared, which is enough to flush it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Decode the FIFO head into an optional prefix cell plus the main cell.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    dec_ok       = 1'b0;
    dec_pre      = 1'b0;
    dec_pre_cell = 6'b000000;
    dec_cell     = 6'b000000;
`ifdef BRAILLE_NUM_EN
    dec_digit    = 1'b0;
`endif
    if (head >= "a" && head <= "z") begin
      dec_ok   = 1'b1;
      dec_cell = letter_cell(head);
`ifdef BRAILLE_NUM_EN
      if (num_mode_q && head <= "j") begin
        dec_pre      = 1'b1;
        dec_pre_cell = G1_SIGN;
      end
`endif
    end else if (head >= "A" && head <= "Z") begin
      dec_ok       = 1'b1;
      dec_pre      = 1'b1;
      dec_pre_cell = CAP_SIGN;
      dec_cell     = letter_cell(head | 8'h20);
    end else if (head == " ") begin
      dec_ok = 1'b1;
`ifdef BRAILLE_NUM_EN
    end else if (head >= "0" && head <= "9") begin
      dec_ok       = 1'b1;
      dec_digit    = 1'b1;
      dec_cell     = (head == "0") ? letter_cell("j") : letter_cell(head + 8'h30);
      dec_pre      = ~num_mode_q;
      dec_pre_cell = NUM_SIGN;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_cell_d  = out_cell_q;
    main_cell_d = main_cell_q;
    err_d       = 1'b0;
    pop         = 1'b0;
`ifdef BRAILLE_NUM_EN
    num_mode_d  = num_mode_q;
    digit_d     = digit_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (level_q != '0) begin
          if (dec_ok) begin
            out_valid_d = 1'b1;
            out_cell_d  = dec_pre ? dec_pre_cell : dec_cell;
            main_cell_d = dec_cell;
            state_d     = dec_pre ? ST_PRE : ST_CELL;
`ifdef BRAILLE_NUM_EN
            digit_d     = dec_digit;
`endif
          end else begin
            pop   = 1'b1;
            err_d = 1'b1;
`ifdef BRAILLE_NUM_EN
            num_mode_d = 1'b0;
`endif
          end
        end
      end
      ST_PRE: begin
        if (out_ready) begin
          out_cell_d = main_cell_q;
          state_d    = ST_CELL;
        end
      end
      ST_CELL: begin
        // The character leaves the FIFO only once its last cell is accepted.
        if (out_ready) begin
          pop         = 1'b1;
          out_valid_d = 1'b0;
          state_d     = ST_FETCH;
`ifdef BRAILLE_NUM_EN
          num_mode_d  = digit_q;
`endif
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      out_valid_q <= 1'b0;
      out_cell_q  <= 6'b000000;
      main_cell_q <= 6'b000000;
      err_q       <= 1'b0;
`ifdef BRAILLE_NUM_EN
      num_mode_q  <= 1'b0;
      digit_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_cell_q  <= out_cell_d;
      main_cell_q <= main_cell_d;
      err_q       <= err_d;
`ifdef BRAILLE_NUM_EN
      num_mode_q  <= num_mode_d;
      digit_q     <= digit_d;
`endif
    end
  end

  assign in_ready   = (level_q != LEVEL_FULL);
  assign out_valid  = out_valid_q;
  assign out_cell   = out_cell_q;
  assign fifo_level = level_q;
  assign err_pulse  = err_q;
  assign busy       = (level_q != '0) | out_valid_q;

endmodule

// File: tb/tb_braille_stream_encoder.sv
// Self-checking bench for braille_stream_encoder: a character-level reference model expands
// every accepted byte into its expected cells; a negedge monitor compares each handshake.
module tb_braille_stream_encoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, err_pulse, busy;
  logic [7:0] in_char;
  logic [5:0] out_cell;
  logic [3:0] fifo_level;

  braille_stream_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_cell(out_cell),
    .fifo_level(fifo_level), .err_pulse(err_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [5:0] tbl [26];
  logic [5:0] exp_q [$];
  logic [5:0] got_q [$];
  int         exp_err = 0;
  int         err_seen = 0;
  bit         m_num = 1'b0;
  bit         hold_v = 1'b0;
  logic [5:0] hold_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one accepted character -> its full list of expected cells.
  task automatic model_push(input logic [7:0] ch);
    if (ch >= 8'h61 && ch <= 8'h7a) begin
`ifdef BRAILLE_NUM_EN
      if (m_num && ch <= 8'h6a) exp_q.push_back(6'b110000);
`endif
      exp_q.push_back(tbl[ch - 8'h61]);
      m_num = 1'b0;
    end else if (ch >= 8'h41 && ch <= 8'h5a) begin
      exp_q.push_back(6'b100000);
      exp_q.push_back(tbl[ch - 8'h41]);
      m_num = 1'b0;
    end else if (ch == 8'h20) begin
      exp_q.push_back(6'b000000);
      m_num = 1'b0;
`ifdef BRAILLE_NUM_EN
    end else if (ch >= 8'h30 && ch <= 8'h39) begin
      if (!m_num) exp_q.push_back(6'b111100);
      exp_q.push_back(ch == 8'h30 ? tbl[9] : tbl[ch - 8'h31]);
      m_num = 1'b1;
`endif
    end else begin
      exp_err++;
      m_num = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_num  = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_cell", out_cell, hold_c);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_cell);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cell: got %b expected no cell", out_cell);
        end else begin
          check("out_cell", out_cell, exp_q.pop_front());
        end
      end
      hold_v = out_valid && !out_ready;
      hold_c = out_cell;
      check("in_ready_vs_level", in_ready, fifo_level != 4'(DEPTH));
      if (in_valid && in_ready) model_push(in_char);
      if (err_pulse) err_seen++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drained"}, n < 200, 1);
    check({name, "_err_count"}, err_seen, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = 6'b000001; tbl[1] = 6'b000011; tbl[2] = 6'b001001; tbl[3] = 6'b011001;
    tbl[4] = 6'b010001; tbl[5] = 6'b001011; tbl[6] = 6'b011011; tbl[7] = 6'b010011;
    tbl[8] = 6'b001010; tbl[9] = 6'b011010;
    for (int i = 10; i < 20; i++) tbl[i] = tbl[i - 10] | 6'b000100;
    tbl[20] = tbl[0] | 6'b100100; tbl[21] = tbl[1] | 6'b100100;
    tbl[22] = 6'b111010;
    tbl[23] = tbl[2] | 6'b100100; tbl[24] = tbl[3] | 6'b100100;
    tbl[25] = tbl[4] | 6'b100100;

    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_cell", out_cell, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // 1: "ab" latency and idle FETCH cycle between cells
    out_ready = 1'b1;
    in_valid = 1'b1; in_char = "a";
    tick();
    check("t1_latency_t1", out_valid, 0);
    in_char = "b";
    tick();
    in_valid = 1'b0;
    check("t1_latency_t2", out_valid, 1);
    check("t1_cell_a", out_cell, 6'b000001);
    tick();
    check("t1_idle_fetch", out_valid, 0);
    tick();
    check("t1_cell_b_valid", out_valid, 1);
    check("t1_cell_b", out_cell, 6'b000011);
    wait_drain("t1");

    // 2: "Hi" with a 5-cycle stall on the 'h' cell
    in_valid = 1'b1; in_char = "H";
    tick();
    in_char = "i";
    tick();
    in_valid = 1'b0;
    check("t2_cap_sign", out_cell, 6'b100000);
    tick();
    out_ready = 1'b0;
    check("t2_cell_h", out_cell, 6'b010011);
    repeat (5) tick();
    check("t2_stall_valid", out_valid, 1);
    check("t2_stall_cell", out_cell, 6'b010011);
    out_ready = 1'b1;
    wait_drain("t2");

    // 3: overfill with out_ready low, then drain in order
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      in_valid = 1'b1;
      in_char  = 8'h61 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    check("t3_level_full", fifo_level, DEPTH);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_head_cell", out_cell, 6'b000001);
    check("t3_accepted", exp_q.size(), DEPTH);
    out_ready = 1'b1;
    wait_drain("t3");

    // 4: unsupported '#' dropped, then 'z'
    in_valid = 1'b1; in_char = "#";
    tick();
    in_char = "z";
    tick();
    in_valid = 1'b0;
    check("t4_err_pulse", err_pulse, 1);
    check("t4_level_after_drop", fifo_level, 1);
    tick();
    check("t4_err_single", err_pulse, 0);
    check("t4_cell_z", out_cell, 6'b110101);
    wait_drain("t4");

    // 5: "12a"
    got_q.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_char  = (k == 0) ? "1" : (k == 1) ? "2" : "a";
      tick();
    end
    in_valid = 1'b0;
    wait_drain("t5");
`ifdef BRAILLE_NUM_EN
    check("t5_cell_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("t5_num_sign", got_q[0], 6'b111100);
      check("t5_digit1", got_q[1], 6'b000001);
      check("t5_digit2", got_q[2], 6'b000011);
      check("t5_grade1", got_q[3], 6'b110000);
      check("t5_letter_a", got_q[4], 6'b000001);
    end
`else
    check("t5_cell_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t5_letter_a", got_q[0], 6'b000001);
`endif

    // 6: reset while the capital sign is held, then a clean 'c'
    out_ready = 1'b0;
    in_valid = 1'b1; in_char = "A";
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_cell", out_cell, 6'b100000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cell", out_cell, 0);
    got_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_char = "c";
    tick();
    in_valid = 1'b0;
    wait_drain("t6");
    check("t6_cell_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t6_cell_c", got_q[0], 6'b001001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
